// File: rtl/led_display_package.sv
// Shared LED matrix row types, geometry constants and helpers for the row stream PHY.
package led_display_package;

  localparam int GL_NUM_COL_PIXELS   = 16;
  localparam int GL_NUM_COL_PIXELS_W = $clog2(GL_NUM_COL_PIXELS);
  localparam int GL_RGB_ROW_W        = 6 * GL_NUM_COL_PIXELS;
  localparam int GL_RX_STAT_W        = 16;

  typedef logic [GL_NUM_COL_PIXELS-1:0] col_vec_t;

  typedef struct packed {
    col_vec_t red_top;
    col_vec_t green_top;
    col_vec_t blue_top;
    col_vec_t red_bot;
    col_vec_t green_bot;
    col_vec_t blue_bot;
  } rgb_row_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  // b = {red_top, green_top, blue_top, red_bot, green_bot, blue_bot}
  function automatic rgb_row_t shift_row(rgb_row_t r, logic [5:0] b);
    rgb_row_t s;
    s.red_top   = {r.red_top[GL_NUM_COL_PIXELS-2:0],   b[5]};
    s.green_top = {r.green_top[GL_NUM_COL_PIXELS-2:0], b[4]};
    s.blue_top  = {r.blue_top[GL_NUM_COL_PIXELS-2:0],  b[3]};
    s.red_bot   = {r.red_bot[GL_NUM_COL_PIXELS-2:0],   b[2]};
    s.green_bot = {r.green_bot[GL_NUM_COL_PIXELS-2:0], b[1]};
    s.blue_bot  = {r.blue_bot[GL_NUM_COL_PIXELS-2:0],  b[0]};
    return s;
  endfunction

endpackage

// File: rtl/led_display_rx_sync.sv
// Multi-flop synchroniser for asynchronous pins plus a registered rising-edge strobe.
module led_display_rx_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]                  sync_d_q;
  logic [WIDTH-1:0]                  rise_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q  <= '0;
      sync_d_q <= '0;
      rise_q   <= '0;
    end else begin
      stage_q  <= {stage_q[SYNC_STAGES-2:0], async_i};
      sync_d_q <= stage_q[SYNC_STAGES-1];
      rise_q   <= stage_q[SYNC_STAGES-1] & ~sync_d_q;
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/led_display_rx_phy.sv
// Receive PHY: deserialises the LED row stream into rgb_row_t with valid/ready output.
// Define LED_RX_STATS_EN to enable the row and error statistics counters.
module led_display_rx_phy
  import led_display_package::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SYS_CLK_FREQ = 100_000_000
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    bit_clk_in,
  input  logic                    latch_in,
  input  logic                    red_top_in,
  input  logic                    green_top_in,
  input  logic                    blue_top_in,
  input  logic                    red_bot_in,
  input  logic                    green_bot_in,
  input  logic                    blue_bot_in,
  output logic                    row_valid_out,
  output rgb_row_t                row_out,
  input  logic                    row_ready_in,
  output logic                    frame_err_out,
  output logic                    overflow_out,
  output logic [GL_RX_STAT_W-1:0] rx_row_count_out,
  output logic [GL_RX_STAT_W-1:0] rx_err_count_out
);

  localparam int CW = GL_NUM_COL_PIXELS_W + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(GL_NUM_COL_PIXELS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(GL_NUM_COL_PIXELS + 1);

  logic [7:0] pins, pins_s, pins_r;
  logic       bit_rise, latch_rise;
  logic [5:0] data;
  logic       unused_sync;

  assign pins = {bit_clk_in, latch_in,
                 red_top_in, green_top_in, blue_top_in,
                 red_bot_in, green_bot_in, blue_bot_in};

  led_display_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (8)
  ) u_sync (
    .clk_i  (clk_in),
    .rst_i  (reset_in),
    .async_i(pins),
    .sync_o (pins_s),
    .rise_o (pins_r)
  );

  assign bit_rise    = pins_r[7];
  assign latch_rise  = pins_r[6];
  assign data        = pins_s[5:0];
  assign unused_sync = ^{pins_r[5:0], pins_s[7:6], SYS_CLK_FREQ[0]};

  rx_state_t     state_q;
  rgb_row_t      sh_q, sh_d, row_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, ferr_q, ovf_q;
  logic          buf_free, commit, drop_ovf, drop_err;

  // A bit arriving with the latch is shifted in before the latch is judged.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (bit_rise) begin
      sh_d = shift_row(sh_q, data);
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
  end

  assign buf_free = !valid_q || row_ready_in;
  assign commit   = latch_rise && (cnt_d == CNT_FULL) && buf_free;
  assign drop_ovf = latch_rise && (cnt_d == CNT_FULL) && !buf_free;
  assign drop_err = latch_rise && (cnt_d != CNT_FULL);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= RX_IDLE;
      sh_q    <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      ferr_q <= drop_err;
      ovf_q  <= drop_ovf;
      if (valid_q && row_ready_in) valid_q <= 1'b0;
      if (commit) begin
        row_q   <= sh_d;
        valid_q <= 1'b1;
      end
      unique case (state_q)
        RX_IDLE: begin
          if (latch_rise) cnt_q <= '0;
          else if (bit_rise) state_q <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (latch_rise) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign row_valid_out = valid_q;
  assign row_out       = row_q;
  assign frame_err_out = ferr_q;
  assign overflow_out  = ovf_q;

`ifdef LED_RX_STATS_EN
  logic [GL_RX_STAT_W-1:0] rows_q, errs_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rows_q <= '0;
      errs_q <= '0;
    end else begin
      if (commit) rows_q <= rows_q + 1'b1;
      if (drop_ovf || drop_err) errs_q <= errs_q + 1'b1;
    end
  end

  assign rx_row_count_out = rows_q;
  assign rx_err_count_out = errs_q;
`else
  assign rx_row_count_out = '0;
  assign rx_err_count_out = '0;
`endif

endmodule

// File: tb/tb_led_display_rx_phy.sv
// Directed bench for led_display_rx_phy with bit_clk running at clk_in/4.
module tb_led_display_rx_phy;
  import led_display_package::*;

  localparam int N = GL_NUM_COL_PIXELS;

  logic     clk = 1'b0;
  logic     reset, bit_clk, latch, ready;
  logic     rt, gt, bt, rb, gb, bb;
  logic     valid, ferr, ovf;
  rgb_row_t row;
  logic [GL_RX_STAT_W-1:0] row_cnt, err_cnt;

  int passed = 0;
  int total  = 0;
  int ferr_seen = 0;
  int ovf_seen  = 0;

  rgb_row_t row_a, row_b, row_c;

  led_display_rx_phy #(
    .SYNC_STAGES (2),
    .SYS_CLK_FREQ(100_000_000)
  ) dut (
    .clk_in          (clk),
    .reset_in        (reset),
    .bit_clk_in      (bit_clk),
    .latch_in        (latch),
    .red_top_in      (rt),
    .green_top_in    (gt),
    .blue_top_in     (bt),
    .red_bot_in      (rb),
    .green_bot_in    (gb),
    .blue_bot_in     (bb),
    .row_valid_out   (valid),
    .row_out         (row),
    .row_ready_in    (ready),
    .frame_err_out   (ferr),
    .overflow_out    (ovf),
    .rx_row_count_out(row_cnt),
    .rx_err_count_out(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr) ferr_seen++;
    if (ovf) ovf_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic [5:0] b);
    bit_clk = 1'b0;
    tick(1);
    {rt, gt, bt, rb, gb, bb} = b;
    tick(1);
    bit_clk = 1'b1;
    tick(2);
  endtask

  task automatic send_bits(input rgb_row_t r, input int nb);
    for (int i = N - 1; i >= N - nb; i--)
      send_bit({r.red_top[i], r.green_top[i], r.blue_top[i],
                r.red_bot[i], r.green_bot[i], r.blue_bot[i]});
    bit_clk = 1'b0;
    tick(2);
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    tick(2);
    latch = 1'b0;
    tick(6);
  endtask

  task automatic pop_row();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    total++;
    if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid);
    else passed++;
    total++;
    if (row !== rgb_row_t'(0)) $display("FAIL rst_row got %h exp 0", row);
    else passed++;
    total++;
    if ({ferr, ovf} !== 2'b00) $display("FAIL rst_pulses got %b exp 00", {ferr, ovf});
    else passed++;
    total++;
    if ({row_cnt, err_cnt} !== 32'd0) $display("FAIL rst_counters got %h exp 0", {row_cnt, err_cnt});
    else passed++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_row();
    int fb;
    fb = ferr_seen;
    send_bits(row_a, N);
    latch = 1'b1;
    tick(2);
    latch = 1'b0;
    tick(1);
    total++;
    if (valid !== 1'b0) $display("FAIL latency_early got %b exp 0", valid);
    else passed++;
    tick(1);
    total++;
    if (valid !== 1'b1) $display("FAIL latency_valid got %b exp 1", valid);
    else passed++;
    tick(4);
    total++;
    if (row !== row_a) $display("FAIL single_row got %h exp %h", row, row_a);
    else passed++;
    total++;
    if (ferr_seen - fb !== 0) $display("FAIL single_ferr got %0d exp 0", ferr_seen - fb);
    else passed++;
    pop_row();
    total++;
    if (valid !== 1'b0) $display("FAIL single_pop got %b exp 0", valid);
    else passed++;
  endtask

  task automatic test_short_row();
    int fb;
    fb = ferr_seen;
    send_bits(row_b, N - 1);
    pulse_latch();
    total++;
    if (ferr_seen - fb !== 1) $display("FAIL short_ferr got %0d exp 1", ferr_seen - fb);
    else passed++;
    total++;
    if (valid !== 1'b0) $display("FAIL short_valid got %b exp 0", valid);
    else passed++;
    send_bits(row_c, N);
    pulse_latch();
    total++;
    if ({valid, row} !== {1'b1, row_c}) $display("FAIL short_next got %b/%h exp 1/%h", valid, row, row_c);
    else passed++;
    pop_row();
  endtask

  task automatic test_overflow();
    int ob;
    ob = ovf_seen;
    ready = 1'b0;
    send_bits(row_a, N);
    pulse_latch();
    send_bits(row_b, N);
    pulse_latch();
    total++;
    if (ovf_seen - ob !== 1) $display("FAIL ovf_pulse got %0d exp 1", ovf_seen - ob);
    else passed++;
    total++;
    if ({valid, row} !== {1'b1, row_a}) $display("FAIL ovf_held got %b/%h exp 1/%h", valid, row, row_a);
    else passed++;
    pop_row();
    total++;
    if (valid !== 1'b0) $display("FAIL ovf_pop got %b exp 0", valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int ob;
    ob = ovf_seen;
    send_bits(row_a, N);
    pulse_latch();
    send_bits(row_c, N);
    latch = 1'b1;
    tick(2);
    latch = 1'b0;
    tick(1);
    total++;
    if ({valid, row} !== {1'b1, row_a}) $display("FAIL b2b_before got %b/%h exp 1/%h", valid, row, row_a);
    else passed++;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(4);
    total++;
    if ({valid, row} !== {1'b1, row_c}) $display("FAIL b2b_after got %b/%h exp 1/%h", valid, row, row_c);
    else passed++;
    total++;
    if (ovf_seen - ob !== 0) $display("FAIL b2b_ovf got %0d exp 0", ovf_seen - ob);
    else passed++;
    pop_row();
  endtask

  task automatic test_reset_mid_row();
    int fb;
    send_bits(row_b, N / 2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    fb = ferr_seen;
    send_bits(row_c, N);
    pulse_latch();
    total++;
    if ({valid, row} !== {1'b1, row_c}) $display("FAIL midrst_row got %b/%h exp 1/%h", valid, row, row_c);
    else passed++;
    total++;
    if (ferr_seen - fb !== 0) $display("FAIL midrst_ferr got %0d exp 0", ferr_seen - fb);
    else passed++;
    pop_row();
  endtask

  task automatic test_stats();
    logic [31:0] exp_cnt;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      send_bits(row_a, N);
      pulse_latch();
      pop_row();
    end
    send_bits(row_b, N - 3);
    pulse_latch();
`ifdef LED_RX_STATS_EN
    exp_cnt = {16'd3, 16'd1};
`else
    exp_cnt = 32'd0;
`endif
    total++;
    if ({row_cnt, err_cnt} !== exp_cnt) $display("FAIL stats got %h exp %h", {row_cnt, err_cnt}, exp_cnt);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    bit_clk = 1'b0;
    latch = 1'b0;
    ready = 1'b0;
    {rt, gt, bt, rb, gb, bb} = 6'b0;
    row_a = '0;
    row_a.red_top = 16'hAAAA;
    row_b = '0;
    row_b.green_top = 16'h1234;
    row_b.blue_bot = 16'hBEEF;
    row_c = '0;
    row_c.red_bot = 16'h0F0F;
    row_c.green_bot = 16'h00FF;
    row_c.blue_top = 16'hC3A5;
    test_reset();
    test_single_row();
    test_short_row();
    test_overflow();
    test_back_to_back();
    test_reset_mid_row();
    test_stats();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
